// File: rtl/kyber_kem_ctrl.sv
// Sequencer between the AHB register decode and the Kyber KEM core.
// It stages the message, feeds it to the core, and buffers the ciphertext in a show-ahead FIFO.
module kyber_kem_ctrl #(
  parameter int         MSG_WORDS      = 8,
  parameter int         CT_WORDS       = 392,
  parameter int         FIFO_DEPTH     = 16,
  parameter int         TIMEOUT_CYCLES = 65535,
  parameter logic [2:0] K              = 3'd4
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        msg_wr,
  input  logic [31:0] msg_wdata,
  input  logic        cmd_start,
  input  logic        cmd_abort,
  input  logic        ct_rd,
  output logic [31:0] ct_rdata,
  output logic [4:0]  ct_level,
  output logic [3:0]  msg_cnt,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        core_start,
  output logic [2:0]  core_k,
  input  logic        core_req_c,
  output logic [31:0] core_m,
  output logic        core_m_ready,
  input  logic        core_valid_client,
  input  logic [31:0] core_dout_client,
  output logic        core_ready_c
);

  localparam int CT_CW = $clog2(CT_WORDS + 1);
  localparam int FA_W  = $clog2(FIFO_DEPTH);
  localparam int MI_W  = $clog2(MSG_WORDS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_FEED  = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [31:0]      r_msg [MSG_WORDS];
  logic [3:0]       r_msg_cnt;
  logic [2:0]       r_feed_ptr;
  logic [CT_CW-1:0] r_ct_cnt;
  logic [15:0]      r_to_cnt;
  logic             r_done;
  logic             r_core_m_ready;
  logic [31:0]      r_core_m;
  logic [31:0]      r_fifo [FIFO_DEPTH];
  logic [FA_W-1:0]  r_wr_ptr;
  logic [FA_W-1:0]  r_rd_ptr;
  logic [4:0]       r_level;

  logic w_msg_full;
  logic w_start_ok;
  logic w_msg_store;
  logic w_feed_hs;
  logic w_feed_last;
  logic w_ready_c;
  logic w_push;
  logic w_pop;
  logic w_ct_last;
  logic w_in_xfer;
  logic w_to_hit;

  assign w_msg_full  = (r_msg_cnt == 4'(MSG_WORDS));
  assign w_start_ok  = (r_state == S_IDLE) && cmd_start && w_msg_full;
  assign w_msg_store = (r_state == S_IDLE) && msg_wr && !w_msg_full;
  // A new word is handed over only when the previous ready pulse has ended.
  assign w_feed_hs   = (r_state == S_FEED) && core_req_c && !r_core_m_ready;
  assign w_feed_last = w_feed_hs && (r_feed_ptr == 3'(MSG_WORDS - 1));
  assign w_ready_c   = (r_state == S_RUN) && (r_level < 5'(FIFO_DEPTH));
  assign w_push      = core_valid_client && w_ready_c;
  assign w_pop       = ct_rd && (r_level != 5'd0);
  assign w_ct_last   = w_push && (r_ct_cnt == CT_CW'(CT_WORDS - 1));
  assign w_in_xfer   = (r_state == S_FEED) || (r_state == S_RUN);
  assign w_to_hit    = w_in_xfer && !w_feed_hs && !w_push &&
                       (r_to_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (cmd_abort) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_start_ok) w_state_next = S_START;
        S_START: w_state_next = S_FEED;
        S_FEED: begin
          if (w_feed_last)   w_state_next = S_RUN;
          else if (w_to_hit) w_state_next = S_ERR;
        end
        S_RUN: begin
          if (w_ct_last)     w_state_next = S_DONE;
          else if (w_to_hit) w_state_next = S_ERR;
        end
        S_DONE:  if (r_level == 5'd0) w_state_next = S_IDLE;
        S_ERR:   w_state_next = S_ERR;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Storage arrays carry no reset; validity is tracked by the counters below.
  always_ff @(posedge hclk) begin
    if (w_msg_store) r_msg[r_msg_cnt[MI_W-1:0]] <= msg_wdata;
    if (w_push)      r_fifo[r_wr_ptr] <= core_dout_client;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_msg_cnt      <= '0;
      r_feed_ptr     <= '0;
      r_ct_cnt       <= '0;
      r_to_cnt       <= '0;
      r_done         <= 1'b0;
      r_core_m_ready <= 1'b0;
      r_core_m       <= '0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_level        <= '0;
    end else if (cmd_abort) begin
      r_msg_cnt      <= '0;
      r_feed_ptr     <= '0;
      r_ct_cnt       <= '0;
      r_to_cnt       <= '0;
      r_done         <= 1'b0;
      r_core_m_ready <= 1'b0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_level        <= '0;
    end else begin
      r_core_m_ready <= w_feed_hs;
      if (w_msg_store) r_msg_cnt <= r_msg_cnt + 4'd1;
      if (w_start_ok)  r_done <= 1'b0;
      if (r_state == S_START) begin
        r_feed_ptr <= '0;
        r_to_cnt   <= '0;
      end
      if (w_feed_hs) begin
        r_core_m <= r_msg[r_feed_ptr];
        if (!w_feed_last) r_feed_ptr <= r_feed_ptr + 3'd1;
      end
      if (w_feed_last) r_ct_cnt <= '0;
      if (w_in_xfer) begin
        if (w_feed_hs || w_push) r_to_cnt <= '0;
        else                     r_to_cnt <= r_to_cnt + 16'd1;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + FA_W'(1);
        r_ct_cnt <= r_ct_cnt + CT_CW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + FA_W'(1);
      r_level <= r_level + {4'd0, w_push} - {4'd0, w_pop};
      if (w_ct_last) begin
        r_done    <= 1'b1;
        r_msg_cnt <= '0;
      end
    end
  end

  assign ct_rdata     = (r_level == 5'd0) ? 32'h0 : r_fifo[r_rd_ptr];
  assign ct_level     = r_level;
  assign msg_cnt      = r_msg_cnt;
  assign busy         = (r_state == S_START) || (r_state == S_FEED) || (r_state == S_RUN);
  assign done         = r_done;
  assign error        = (r_state == S_ERR);
  assign core_start   = (r_state == S_START);
  assign core_k       = K;
  assign core_m       = r_core_m;
  assign core_m_ready = r_core_m_ready;
  assign core_ready_c = w_ready_c;

endmodule

// File: tb/tb_kyber_kem_ctrl.sv
// Self-checking bench for kyber_kem_ctrl: vector table for load/start gating, queue model for
// randomized ciphertext streaming, and directed sequences for reset, timeout and abort races.
module tb_kyber_kem_ctrl;

  localparam int CT         = 20;
  localparam int TO         = 100;
  localparam int DEPTH      = 16;
  localparam int PH_IDLE    = 0;
  localparam int PH_RUN     = 1;
  localparam int PH_DONE    = 2;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        msg_wr;
  logic [31:0] msg_wdata;
  logic        cmd_start;
  logic        cmd_abort;
  logic        ct_rd;
  logic [31:0] ct_rdata;
  logic [4:0]  ct_level;
  logic [3:0]  msg_cnt;
  logic        busy;
  logic        done;
  logic        error;
  logic        core_start;
  logic [2:0]  core_k;
  logic        core_req_c;
  logic [31:0] core_m;
  logic        core_m_ready;
  logic        core_valid_client;
  logic [31:0] core_dout_client;
  logic        core_ready_c;

  kyber_kem_ctrl #(
    .MSG_WORDS(8), .CT_WORDS(CT), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO), .K(3'd4)
  ) dut (
    .hclk(hclk), .hresetn(hresetn), .msg_wr(msg_wr), .msg_wdata(msg_wdata),
    .cmd_start(cmd_start), .cmd_abort(cmd_abort), .ct_rd(ct_rd), .ct_rdata(ct_rdata),
    .ct_level(ct_level), .msg_cnt(msg_cnt), .busy(busy), .done(done), .error(error),
    .core_start(core_start), .core_k(core_k), .core_req_c(core_req_c), .core_m(core_m),
    .core_m_ready(core_m_ready), .core_valid_client(core_valid_client),
    .core_dout_client(core_dout_client), .core_ready_c(core_ready_c)
  );

  always #5 hclk = ~hclk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] q[$];
  logic [31:0] m[8];
  logic [31:0] ct_base;
  int          sent;
  int          rx;
  int          ph;
  bit          exp_done;

  typedef struct {
    bit          wr;
    logic [31:0] d;
    bit          st;
    logic [3:0]  e_cnt;
    bit          e_busy;
    bit          e_cs;
  } vec_t;
  vec_t tv[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic load_and_start();
    for (int i = 0; i < 8; i++) begin
      m[i] = $urandom;
      msg_wr = 1'b1;
      msg_wdata = m[i];
      tick();
      chk("load_cnt", 32'(msg_cnt), 32'(i + 1));
    end
    msg_wr = 1'b0;
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    exp_done = 1'b0;
    chk("start_pulse", 32'(core_start), 32'd1);
    chk("start_done_clr", 32'(done), 32'd0);
    tick();
    chk("start_pulse_end", 32'(core_start), 32'd0);
    chk("feed_busy", 32'(busy), 32'd1);
    $display("start: message staged, core launched");
  endtask

  task automatic feed_all();
    for (int i = 0; i < 8; i++) begin
      core_req_c = 1'b1;
      tick();
      chk("feed_ready", 32'(core_m_ready), 32'd1);
      chk($sformatf("feed_word%0d", i), core_m, m[i]);
      if (i < 7) chk("feed_ready_c_low", 32'(core_ready_c), 32'd0);
      core_req_c = 1'b0;
      tick();
      chk("feed_ready_pulse", 32'(core_m_ready), 32'd0);
    end
    $display("feed: 8 message words delivered");
    ph = PH_RUN;
    sent = 0;
    rx = 0;
    q.delete();
  endtask

  // One cycle of ciphertext streaming against the queue model.
  task automatic cyc(input bit v, input bit rd);
    bit          exp_rdy;
    bit          acc;
    bit          pop;
    bit          leave_done;
    logic [31:0] w;
    exp_rdy = (ph == PH_RUN) && (q.size() < DEPTH);
    chk("core_ready_c", 32'(core_ready_c), 32'(exp_rdy));
    w = ct_base + 32'(sent);
    core_valid_client = v;
    core_dout_client = w;
    ct_rd = rd;
    pop = rd && (q.size() > 0);
    if (pop) begin
      chk($sformatf("rx_word%0d", rx), ct_rdata, ct_base + 32'(rx));
      rx++;
    end
    acc = v && exp_rdy;
    leave_done = (ph == PH_DONE) && (q.size() == 0);
    tick();
    if (pop) void'(q.pop_front());
    if (acc) begin
      q.push_back(w);
      sent++;
      if (sent == CT) begin
        ph = PH_DONE;
        exp_done = 1'b1;
      end
    end else if (leave_done) begin
      ph = PH_IDLE;
    end
    chk("ct_level", 32'(ct_level), 32'(q.size()));
    chk("ct_rdata", ct_rdata, (q.size() > 0) ? q[0] : 32'h0);
    chk("done", 32'(done), 32'(exp_done));
    chk("busy", 32'(busy), 32'(ph == PH_RUN));
    chk("msg_cnt", 32'(msg_cnt), (ph == PH_RUN) ? 32'd8 : 32'd0);
  endtask

  task automatic run_until_idle(input int pv, input int pr);
    int n = 0;
    while (ph != PH_IDLE && n < 400) begin
      cyc(($urandom % 100) < pv, ($urandom % 100) < pr);
      n++;
    end
    core_valid_client = 1'b0;
    ct_rd = 1'b0;
    chk("run_bound", 32'(ph), 32'(PH_IDLE));
    chk("rx_total", 32'(rx), 32'(CT));
    chk("done_final", 32'(done), 32'd1);
    $display("encap: %0d words received in %0d cycles", rx, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    hresetn = 1'b0; msg_wr = 1'b0; msg_wdata = '0; cmd_start = 1'b0; cmd_abort = 1'b0;
    ct_rd = 1'b0; core_req_c = 1'b0; core_valid_client = 1'b0; core_dout_client = '0;
    ph = PH_IDLE; exp_done = 1'b0; sent = 0; rx = 0; ct_base = '0;

    tv[0]  = '{1, 32'h11111111, 0, 4'd1, 0, 0};
    tv[1]  = '{1, 32'h22222222, 0, 4'd2, 0, 0};
    tv[2]  = '{1, 32'h33333333, 0, 4'd3, 0, 0};
    tv[3]  = '{1, 32'h44444444, 0, 4'd4, 0, 0};
    tv[4]  = '{1, 32'h55555555, 0, 4'd5, 0, 0};
    tv[5]  = '{0, 32'h0,        1, 4'd5, 0, 0};
    tv[6]  = '{0, 32'h0,        0, 4'd5, 0, 0};
    tv[7]  = '{1, 32'h66666666, 0, 4'd6, 0, 0};
    tv[8]  = '{1, 32'h77777777, 0, 4'd7, 0, 0};
    tv[9]  = '{1, 32'h88888888, 0, 4'd8, 0, 0};
    tv[10] = '{1, 32'h99999999, 0, 4'd8, 0, 0};
    tv[11] = '{0, 32'h0,        1, 4'd8, 1, 1};
    tv[12] = '{0, 32'h0,        0, 4'd8, 1, 0};

    tick();
    tick();
    chk("rst_ct_level", 32'(ct_level), 32'd0);
    chk("rst_ct_rdata", ct_rdata, 32'd0);
    chk("rst_msg_cnt", 32'(msg_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flags", {29'd0, done, error, core_start}, 32'd0);
    chk("rst_core_k", 32'(core_k), 32'd4);
    chk("rst_core_outs", {30'd0, core_m_ready, core_ready_c}, 32'd0);
    hresetn = 1'b1;
    $display("reset: outputs checked");

    for (int i = 0; i < 13; i++) begin
      msg_wr = tv[i].wr;
      msg_wdata = tv[i].d;
      cmd_start = tv[i].st;
      tick();
      chk($sformatf("vec%0d_cnt", i), 32'(msg_cnt), 32'(tv[i].e_cnt));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tv[i].e_busy));
      chk($sformatf("vec%0d_cs", i), 32'(core_start), 32'(tv[i].e_cs));
      $display("vec %0d: wr=%0d start=%0d msg_cnt=%0d busy=%0d", i, tv[i].wr, tv[i].st, msg_cnt, busy);
    end
    msg_wr = 1'b0;
    cmd_start = 1'b0;
    for (int i = 0; i < 8; i++) m[i] = 32'h11111111 * 32'(i + 1);
    feed_all();
    chk("run_ready_c", 32'(core_ready_c), 32'd1);

    ct_base = 32'h0;
    run_until_idle(70, 100);

    // Backpressure: fill the FIFO, core holds word 16, then a single pop lets it in.
    load_and_start();
    feed_all();
    ct_base = 32'hB0000000;
    for (int i = 0; i < DEPTH + 3; i++) cyc(1'b1, 1'b0);
    chk("bp_sent_held", 32'(sent), 32'(DEPTH));
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    chk("bp_word16_in", 32'(sent), 32'(DEPTH + 1));
    $display("backpressure: FIFO full held word %0d until one pop", DEPTH);
    run_until_idle(60, 60);

    for (int r = 0; r < 3; r++) begin
      load_and_start();
      feed_all();
      ct_base = $urandom & 32'hFFFF0000;
      run_until_idle(50, 50);
    end

    // Asynchronous reset in the middle of the ciphertext phase.
    load_and_start();
    feed_all();
    ct_base = 32'hA0000000;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    core_valid_client = 1'b0;
    #2 hresetn = 1'b0;
    #1;
    chk("mid_rst_ct_level", 32'(ct_level), 32'd0);
    chk("mid_rst_ct_rdata", ct_rdata, 32'd0);
    chk("mid_rst_msg_cnt", 32'(msg_cnt), 32'd0);
    chk("mid_rst_flags", {28'd0, busy, done, error, core_start}, 32'd0);
    chk("mid_rst_core", {30'd0, core_m_ready, core_ready_c}, 32'd0);
    chk("mid_rst_core_m", core_m, 32'd0);
    chk("mid_rst_core_k", 32'(core_k), 32'd4);
    tick();
    hresetn = 1'b1;
    ph = PH_IDLE; q.delete(); exp_done = 1'b0;
    $display("reset mid-run: outputs returned to reset values");

    // Timeout in FEED: core never requests a word.
    load_and_start();
    n = 1;
    while (!error && n < 300) begin
      tick();
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'(TO + 1));
    chk("timeout_busy", 32'(busy), 32'd0);
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    chk("abort_error", 32'(error), 32'd0);
    chk("abort_level", 32'(ct_level), 32'd0);
    chk("abort_msg_cnt", 32'(msg_cnt), 32'd0);
    $display("timeout: error after %0d cycles, cleared by abort", n);

    // Abort coinciding with the final ciphertext transfer.
    load_and_start();
    feed_all();
    ct_base = 32'hD0000000;
    n = 0;
    while (sent < CT - 1 && n < 200) begin
      cyc(1'($urandom % 2), 1'b1);
      n++;
    end
    chk("race_ready", 32'(core_ready_c), 32'd1);
    core_valid_client = 1'b1;
    core_dout_client = ct_base + 32'(CT - 1);
    ct_rd = 1'b0;
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    core_valid_client = 1'b0;
    ph = PH_IDLE; q.delete(); exp_done = 1'b0;
    chk("race_done", 32'(done), 32'd0);
    chk("race_level", 32'(ct_level), 32'd0);
    chk("race_rdata", ct_rdata, 32'd0);
    chk("race_busy", 32'(busy), 32'd0);
    tick();
    chk("race_done_later", 32'(done), 32'd0);
    chk("race_msg_cnt", 32'(msg_cnt), 32'd0);
    $display("abort race: final transfer discarded, controller idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
